// File: rtl/kw_search_pkg.sv
// -----------------------------------------------------------------------------
// kw_search_pkg
// Shared types and default sizes for the keyword-search sequencer.
//   kw_state_t  : controller state encoding
//   DEF_*       : default parameter values used by the top, interface and bench
// -----------------------------------------------------------------------------
package kw_search_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEARCH,
        DRAIN,
        DONE
    } kw_state_t;

    localparam int DEF_CHAR_W     = 8;
    localparam int DEF_KEY_LEN    = 8;
    localparam int DEF_DICT_DEPTH = 256;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_CMP_LAT    = 2;

endpackage

// File: rtl/kw_search_ctrl_if.sv
// -----------------------------------------------------------------------------
// kw_search_ctrl_if
// Bundles the host-side control/status and datapath-side signals of the
// keyword-search sequencer.
//   master : the controller (drives char_ready, ice, ls, sce, scan_addr and
//            the status/result outputs)
//   slave  : the environment (host + datapath; drives start, abort,
//            char_valid, cmp_out)
// -----------------------------------------------------------------------------
interface kw_search_ctrl_if
    import kw_search_pkg::*;
#(
    parameter int CHAR_W = DEF_CHAR_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              start;
    logic              abort;
    logic              char_valid;
    logic              char_ready;
    logic              ice;
    logic              ls;
    logic              sce;
    logic [ADDR_W-1:0] scan_addr;
    logic [CHAR_W-1:0] cmp_out;
    logic              busy;
    logic              done;
    logic              hit;
    logic [ADDR_W-1:0] hit_addr;
    logic [CHAR_W-1:0] hit_code;

    modport master (
        input  start, abort, char_valid, cmp_out,
        output char_ready, ice, ls, sce, scan_addr,
               busy, done, hit, hit_addr, hit_code
    );

    modport slave (
        output start, abort, char_valid, cmp_out,
        input  char_ready, ice, ls, sce, scan_addr,
               busy, done, hit, hit_addr, hit_code
    );
endinterface

// File: rtl/kw_tag_pipe.sv
// -----------------------------------------------------------------------------
// kw_tag_pipe
// DEPTH-stage shift line carrying {valid, address} so each comparator result
// can be matched to the dictionary address that produced it.
//   clk       : clock
//   clr       : synchronous clear of every stage (reset, abort, idle)
//   in_valid  : an address is being issued this cycle
//   in_addr   : the issued address
//   out_valid : tag emerging DEPTH cycles after issue is valid
//   out_addr  : address belonging to that tag
// -----------------------------------------------------------------------------
module kw_tag_pipe #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [ADDR_W:0] stage [DEPTH];

    // NOTE: every stage is cleared, not just the valid bits; the array is a
    // handful of flops, and a stale address must never be tagged valid after
    // an abort flushes the line.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= {in_valid, in_addr};
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign out_valid = stage[DEPTH-1][ADDR_W];
    assign out_addr  = stage[DEPTH-1][ADDR_W-1:0];

endmodule

// File: rtl/kw_search_ctrl.sv
// -----------------------------------------------------------------------------
// kw_search_ctrl
// Sequencer for the keyword-encoder datapath. One search per start: accept
// KEY_LEN query characters (ice/ls pulse per accept), then sweep dictionary
// addresses with sce high, sampling cmp_out CMP_LAT cycles after each address.
// The first nonzero sample ends the search as a hit; otherwise the sweep ends
// as a miss. Either way a one-cycle done pulse follows.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : kw_search_ctrl_if.master (handshake, datapath controls,
//                status and result outputs)
// -----------------------------------------------------------------------------
module kw_search_ctrl
    import kw_search_pkg::*;
#(
    parameter int CHAR_W     = DEF_CHAR_W,
    parameter int KEY_LEN    = DEF_KEY_LEN,
    parameter int DICT_DEPTH = DEF_DICT_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CMP_LAT    = DEF_CMP_LAT
) (
    input logic              clk,
    input logic              rst_n,
    kw_search_ctrl_if.master bus
);

    localparam int                CNT_W     = $clog2(KEY_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_CHAR = CNT_W'(KEY_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DICT_DEPTH - 1);
    localparam logic [CHAR_W-1:0] NO_MATCH  = '0;

    kw_state_t         state;
    logic [CNT_W-1:0]  char_cnt;
    logic [ADDR_W-1:0] scan_addr_q;
    logic [ADDR_W-1:0] hit_addr_q;
    logic [CHAR_W-1:0] hit_code_q;
    logic              char_ready_q;
    logic              sce_q;
    logic              busy_q;
    logic              done_q;
    logic              hit_q;

    logic              accept;
    logic              scanning;
    logic              pipe_clr;
    logic              tag_valid;
    logic [ADDR_W-1:0] tag_addr;
    logic              sample_valid;
    logic              sample_hit;
    logic              last_sample;

    // ice/ls must act in the accept cycle itself, so they are the only
    // combinational controls; everything else is registered with the state.
    assign accept   = bus.char_valid & char_ready_q;
    assign scanning = (state == SEARCH) || (state == DRAIN);

    // The line is held empty outside the sweep, so a new search never sees
    // tags left over from the previous one.
    assign pipe_clr = !rst_n || bus.abort || !scanning;

    kw_tag_pipe #(
        .ADDR_W (ADDR_W),
        .DEPTH  (CMP_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .clr       (pipe_clr),
        .in_valid  (state == SEARCH),
        .in_addr   (scan_addr_q),
        .out_valid (tag_valid),
        .out_addr  (tag_addr)
    );

    assign sample_valid = scanning && tag_valid;
    assign sample_hit   = sample_valid && (bus.cmp_out != NO_MATCH);
    assign last_sample  = sample_valid && (tag_addr == LAST_ADDR);

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch below reads the pre-edge values, independent of order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            char_cnt     <= '0;
            scan_addr_q  <= '0;
            char_ready_q <= 1'b0;
            sce_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hit_q        <= 1'b0;
            hit_addr_q   <= '0;
            hit_code_q   <= '0;
        end else if (bus.abort) begin
            // Results are deliberately kept; only the sequencing is dropped.
            state        <= IDLE;
            char_ready_q <= 1'b0;
            sce_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= LOAD;
                        char_cnt     <= '0;
                        hit_q        <= 1'b0;
                        hit_addr_q   <= '0;
                        hit_code_q   <= '0;
                        char_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        char_cnt <= char_cnt + 1'b1;
                        if (char_cnt == LAST_CHAR) begin
                            state        <= SEARCH;
                            char_ready_q <= 1'b0;
                            sce_q        <= 1'b1;
                            scan_addr_q  <= '0;
                        end
                    end
                end
                SEARCH, DRAIN: begin
                    if (sample_hit) begin
                        state      <= DONE;
                        sce_q      <= 1'b0;
                        done_q     <= 1'b1;
                        hit_q      <= 1'b1;
                        hit_addr_q <= tag_addr;
                        hit_code_q <= bus.cmp_out;
                    end else if (state == DRAIN) begin
                        if (last_sample) begin
                            state  <= DONE;
                            sce_q  <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end else if (scan_addr_q == LAST_ADDR) begin
                        // Last address issued; hold it while results drain.
                        state <= DRAIN;
                    end else begin
                        scan_addr_q <= scan_addr_q + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.char_ready = char_ready_q;
    assign bus.ice        = accept;
    assign bus.ls         = accept;
    assign bus.sce        = sce_q;
    assign bus.scan_addr  = scan_addr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.hit        = hit_q;
    assign bus.hit_addr   = hit_addr_q;
    assign bus.hit_code   = hit_code_q;

endmodule

// File: tb/tb_kw_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kw_search_ctrl
// Self-checking bench for kw_search_ctrl. A dictionary array stands in for the
// datapath: cmp_out answers each issued address CMP_LAT cycles later. Expected
// results come from scanning that array for the first nonzero entry.
// -----------------------------------------------------------------------------
module tb_kw_search_ctrl;
    import kw_search_pkg::*;

    localparam int CHAR_W     = DEF_CHAR_W;
    localparam int KEY_LEN    = DEF_KEY_LEN;
    localparam int DICT_DEPTH = DEF_DICT_DEPTH;
    localparam int ADDR_W     = DEF_ADDR_W;
    localparam int CMP_LAT    = DEF_CMP_LAT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kw_search_ctrl_if #(.CHAR_W(CHAR_W), .ADDR_W(ADDR_W)) bus ();

    kw_search_ctrl #(
        .CHAR_W     (CHAR_W),
        .KEY_LEN    (KEY_LEN),
        .DICT_DEPTH (DICT_DEPTH),
        .ADDR_W     (ADDR_W),
        .CMP_LAT    (CMP_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [CHAR_W-1:0] dict      [DICT_DEPTH];
    logic [ADDR_W-1:0] addr_hist [CMP_LAT+1];
    logic              vld_hist  [CMP_LAT+1];

    // Datapath stand-in: entry k holds what was on scan_addr/sce k cycles ago.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k <= CMP_LAT; k++) begin
                addr_hist[k] <= '0;
                vld_hist[k]  <= 1'b0;
            end
        end else begin
            addr_hist[0] <= bus.scan_addr;
            vld_hist[0]  <= bus.sce;
            for (int k = 1; k <= CMP_LAT; k++) begin
                addr_hist[k] <= addr_hist[k-1];
                vld_hist[k]  <= vld_hist[k-1];
            end
        end
    end

    assign bus.cmp_out = (vld_hist[CMP_LAT] === 1'b1) ? dict[addr_hist[CMP_LAT]] : '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [CHAR_W-1:0] rand_code();
        return CHAR_W'($urandom_range(1, (1 << CHAR_W) - 1));
    endfunction

    task automatic clear_dict();
        for (int a = 0; a < DICT_DEPTH; a++) dict[a] = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_char_ready"}, 32'(bus.char_ready), 32'd0);
        check({tag, "_ice"},        32'(bus.ice),        32'd0);
        check({tag, "_ls"},         32'(bus.ls),         32'd0);
        check({tag, "_sce"},        32'(bus.sce),        32'd0);
        check({tag, "_scan_addr"},  32'(bus.scan_addr),  32'd0);
        check({tag, "_busy"},       32'(bus.busy),       32'd0);
        check({tag, "_done"},       32'(bus.done),       32'd0);
        check({tag, "_hit"},        32'(bus.hit),        32'd0);
        check({tag, "_hit_addr"},   32'(bus.hit_addr),   32'd0);
        check({tag, "_hit_code"},   32'(bus.hit_code),   32'd0);
    endtask

    // One complete search against the current dictionary contents.
    task automatic run_search(input string tag, input int gap_pct, input bit start_noise);
        logic              exp_hit;
        int                exp_addr, exp_done, exp_max;
        logic [CHAR_W-1:0] exp_code;
        int                sent, ice_cnt, guard, s, done_cyc, max_addr, seq_err, want_addr;

        exp_hit  = 1'b0;
        exp_addr = 0;
        exp_code = '0;
        for (int a = 0; a < DICT_DEPTH; a++) begin
            if (!exp_hit && dict[a] != '0) begin
                exp_hit  = 1'b1;
                exp_addr = a;
                exp_code = dict[a];
            end
        end
        exp_done = exp_hit ? exp_addr + CMP_LAT + 1 : DICT_DEPTH + CMP_LAT;
        exp_max  = exp_hit ? exp_addr + CMP_LAT : DICT_DEPTH - 1;
        if (exp_max > DICT_DEPTH - 1) exp_max = DICT_DEPTH - 1;

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);

        // Load phase: ice/ls must follow char_valid exactly while loading.
        sent    = 0;
        guard   = 0;
        seq_err = 0;
        forever begin
            bus.char_valid = ($urandom_range(99) >= gap_pct);
            if (start_noise) bus.start = 1'($urandom_range(1));
            #1;
            if (bus.ice !== bus.char_valid) seq_err++;
            if (bus.ls !== bus.ice) seq_err++;
            if (bus.ice === 1'b1) sent++;
            guard++;
            if (sent == KEY_LEN || guard > 200) break;
            @(negedge clk);
        end
        check({tag, "_loaded"}, 32'(sent), 32'(KEY_LEN));
        ice_cnt = sent;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;

        // Sweep phase: s counts cycles from the first SEARCH cycle.
        s        = 0;
        done_cyc = -1;
        max_addr = 0;
        while (done_cyc < 0 && s < DICT_DEPTH + CMP_LAT + 50) begin
            @(negedge clk);
            bus.char_valid = 1'($urandom_range(1));
            if (start_noise) bus.start = 1'($urandom_range(1));
            #1;
            if (bus.ice === 1'b1) ice_cnt++;
            if (bus.busy !== 1'b1) seq_err++;
            if (bus.done === 1'b1) begin
                done_cyc = s;
            end else begin
                if (bus.sce !== 1'b1) begin
                    seq_err++;
                end else begin
                    want_addr = (s < DICT_DEPTH) ? s : DICT_DEPTH - 1;
                    if (int'(bus.scan_addr) != want_addr) seq_err++;
                    if (int'(bus.scan_addr) > max_addr) max_addr = int'(bus.scan_addr);
                end
                s++;
            end
        end
        bus.char_valid = 1'b0;
        bus.start      = 1'b0;

        check({tag, "_done_cycle"}, 32'(done_cyc),     32'(exp_done));
        check({tag, "_hit"},        32'(bus.hit),      32'(exp_hit));
        check({tag, "_hit_addr"},   32'(bus.hit_addr), 32'(exp_addr));
        check({tag, "_hit_code"},   32'(bus.hit_code), 32'(exp_code));
        check({tag, "_max_addr"},   32'(max_addr),     32'(exp_max));
        check({tag, "_ice_cycles"}, 32'(ice_cnt),      32'(KEY_LEN));
        check({tag, "_seq_errors"}, 32'(seq_err),      32'd0);

        @(negedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_busy_fall"},  32'(bus.busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_done;

        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.char_valid = 1'b0;
        clear_dict();

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;

        // Single match, back-to-back load.
        clear_dict();
        dict[5] = 8'h3C;
        run_search("hit5", 0, 1'b0);

        // start+abort together in IDLE: stays idle, results kept.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.abort = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            #1;
            check("start_abort_busy",     32'(bus.busy),       32'd0);
            check("start_abort_ready",    32'(bus.char_ready), 32'd0);
            check("start_abort_hit",      32'(bus.hit),        32'd1);
            check("start_abort_hit_addr", 32'(bus.hit_addr),   32'd5);
        end

        // Full miss with gaps in the character stream.
        clear_dict();
        run_search("miss", 40, 1'b0);

        // Two matches: only the lower address is reported.
        clear_dict();
        dict[10] = rand_code();
        dict[20] = rand_code();
        run_search("two_hits", 20, 1'b0);

        // Boundary addresses.
        clear_dict();
        dict[DICT_DEPTH-1] = 8'hA5;
        run_search("last_addr", 0, 1'b0);
        clear_dict();
        dict[0] = rand_code();
        run_search("first_addr", 30, 1'b0);

        // start toggling while busy must not disturb the search.
        clear_dict();
        dict[77] = rand_code();
        run_search("busy_start", 30, 1'b1);

        // Random dictionaries.
        for (int r = 0; r < 4; r++) begin
            clear_dict();
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                dict[$urandom_range(DICT_DEPTH - 1)] = rand_code();
            run_search("random", int'($urandom_range(0, 60)), 1'b0);
        end

        // Abort at SEARCH cycle 40 of a search that would hit at 100.
        clear_dict();
        dict[100] = 8'h42;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.char_valid = 1'b1;
        repeat (KEY_LEN) @(negedge clk);
        bus.char_valid = 1'b0;
        repeat (40) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        #1;
        check("abort_busy",  32'(bus.busy),       32'd0);
        check("abort_sce",   32'(bus.sce),        32'd0);
        check("abort_ready", 32'(bus.char_ready), 32'd0);
        n_done = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.done === 1'b1) n_done++;
        end
        check("abort_no_done", 32'(n_done),  32'd0);
        check("abort_hit",     32'(bus.hit), 32'd0);

        // New search, then reset in the middle of loading.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("restart_busy",  32'(bus.busy),       32'd1);
        check("restart_ready", 32'(bus.char_ready), 32'd1);
        bus.char_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.char_valid = 1'b0;
        rst_n          = 1'b0;
        @(negedge clk);
        #1;
        check_quiet("mid_load_reset");
        rst_n  = 1'b1;
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1) n_done++;
        end
        check("post_reset_no_done", 32'(n_done),   32'd0);
        check("post_reset_busy",    32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
